// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the registered RV32I decode stage: opcodes,
// operation-select encodings, immediate formats and the decode helpers.
package id_stage_pipe_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU/branch/load use {2'bxx, funct3}; the remaining codes live in the 01xxx gap.
  localparam logic [4:0] SEL_SB    = 5'b01000;
  localparam logic [4:0] SEL_SH    = 5'b01001;
  localparam logic [4:0] SEL_SW    = 5'b01010;
  localparam logic [4:0] SEL_LUI   = 5'b01100;
  localparam logic [4:0] SEL_AUIPC = 5'b01101;
  localparam logic [4:0] SEL_JAL   = 5'b01110;
  localparam logic [4:0] SEL_JALR  = 5'b01111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] alusel;
    logic       alt;
    logic       rd1;
    logic       rd2;
    logic       wreg;
    logic       illegal;
    imm_fmt_e   fmt;
  } dec_t;

  // Sign-extended 32-bit immediate for the given format.
  function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] inst);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

  // Control decode; anything unrecognised becomes a flagged NOP.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [2:0] f3;
    f3 = inst[14:12];
    d  = '0;
    case (inst[6:0])
      OPC_LUI:    begin d.alusel = SEL_LUI;   d.wreg = WriteEnable; d.fmt = IMM_U; end
      OPC_AUIPC:  begin d.alusel = SEL_AUIPC; d.wreg = WriteEnable; d.fmt = IMM_U; end
      OPC_JAL:    begin d.alusel = SEL_JAL;   d.wreg = WriteEnable; d.fmt = IMM_J; end
      OPC_JALR:   begin
        d.alusel = SEL_JALR; d.wreg = WriteEnable; d.rd1 = 1'b1; d.fmt = IMM_I;
      end
      OPC_BRANCH: begin
        d.alusel = {2'b10, f3}; d.rd1 = 1'b1; d.rd2 = 1'b1; d.fmt = IMM_B;
      end
      OPC_LOAD:   begin
        d.alusel = {2'b11, f3}; d.rd1 = 1'b1; d.wreg = WriteEnable; d.fmt = IMM_I;
      end
      OPC_STORE:  begin
        case (f3)
          3'b000:  begin d.alusel = SEL_SB; d.rd1 = 1'b1; d.rd2 = 1'b1; d.fmt = IMM_S; end
          3'b001:  begin d.alusel = SEL_SH; d.rd1 = 1'b1; d.rd2 = 1'b1; d.fmt = IMM_S; end
          3'b010:  begin d.alusel = SEL_SW; d.rd1 = 1'b1; d.rd2 = 1'b1; d.fmt = IMM_S; end
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        d.alusel = {2'b00, f3}; d.rd1 = 1'b1; d.wreg = WriteEnable; d.fmt = IMM_I;
        // Only SLLI/SRLI/SRAI carry a meaningful funct7[5]
        d.alt    = ((f3 == 3'b001) || (f3 == 3'b101)) ? inst[30] : 1'b0;
      end
      OPC_OP:     begin
        d.alusel = {2'b00, f3}; d.rd1 = 1'b1; d.rd2 = 1'b1; d.wreg = WriteEnable;
        d.alt    = inst[30];
      end
      default:    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Resolves one source operand against the forwarding sources; index 0 is
// the youngest stage and wins even when its result is still pending.
module id_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              addr_i,
  input  logic                    read_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  logic [NUM_FWD-1:0]      fwd_pending_i,
  output logic [XLEN-1:0]         val_o,
  output logic                    hazard_o
);

  logic found;

  // First matching source by priority supplies the value or raises a hazard
  always_comb begin
    val_o    = rf_data_i;
    hazard_o = 1'b0;
    found    = 1'b0;
    if (!read_i || (addr_i == 5'd0)) begin
      val_o = '0;
    end else begin
      for (int k = 0; k < NUM_FWD; k++) begin
        if (!found && fwd_we_i[k] && (fwd_wd_i[5*k +: 5] == addr_i)) begin
          found    = 1'b1;
          val_o    = fwd_data_i[XLEN*k +: XLEN];
          hazard_o = fwd_pending_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with operand forwarding, valid/ready
// handshake towards EX, branch flush and a saturating hazard-stall counter.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [ADDR_W-1:0]       pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  logic [NUM_FWD-1:0]      fwd_pending_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [4:0]              alusel_o,
  output logic                    alt_o,
  output logic [XLEN-1:0]         opr1_o,
  output logic [XLEN-1:0]         opr2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [ADDR_W-1:0]       pc_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic                    illegal_o,
  output logic [31:0]             inst_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  dec_t            dec;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_haz, rs2_haz;
  logic            hazard, in_ready, capture;

  logic              out_valid_q, out_valid_d;
  logic [4:0]        alusel_q, alusel_d;
  logic              alt_q, alt_d;
  logic [XLEN-1:0]   opr1_q, opr1_d;
  logic [XLEN-1:0]   opr2_q, opr2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       inst_q, inst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign reg1_addr_o = inst_i[19:15];
  assign reg2_addr_o = inst_i[24:20];

  // Decode the incoming instruction and widen its immediate to XLEN
  always_comb begin
    dec   = decode(inst_i);
    imm32 = imm_gen(dec.fmt, inst_i);
    imm_x = XLEN'($signed(imm32));
  end

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .addr_i        (reg1_addr_o),
    .read_i        (dec.rd1),
    .rf_data_i     (reg1_data_i),
    .fwd_we_i      (fwd_we_i),
    .fwd_wd_i      (fwd_wd_i),
    .fwd_data_i    (fwd_data_i),
    .fwd_pending_i (fwd_pending_i),
    .val_o         (rs1_val),
    .hazard_o      (rs1_haz)
  );

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .addr_i        (reg2_addr_o),
    .read_i        (dec.rd2),
    .rf_data_i     (reg2_data_i),
    .fwd_we_i      (fwd_we_i),
    .fwd_wd_i      (fwd_wd_i),
    .fwd_data_i    (fwd_data_i),
    .fwd_pending_i (fwd_pending_i),
    .val_o         (rs2_val),
    .hazard_o      (rs2_haz)
  );

  // Handshake: flush always drains the input, otherwise wait on hazard and EX
  always_comb begin
    hazard   = in_valid_i & (rs1_haz | rs2_haz);
    in_ready = flush_i | (~hazard & (~out_valid_q | out_ready_i));
    capture  = in_valid_i & in_ready & ~flush_i;
  end

  assign in_ready_o = in_ready;

  // Next-state of the output register and the stall counter
  always_comb begin
    out_valid_d = out_valid_q;
    alusel_d    = alusel_q;
    alt_d       = alt_q;
    opr1_d      = opr1_q;
    opr2_d      = opr2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    illegal_d   = illegal_q;
    inst_d      = inst_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_i) begin
      out_valid_d = 1'b0;
      wreg_d      = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      alusel_d    = dec.alusel;
      alt_d       = dec.alt;
      opr1_d      = dec.rd1 ? rs1_val : imm_x;
      opr2_d      = dec.rd2 ? rs2_val : imm_x;
      imm_d       = (dec.rd1 && dec.rd2) ? imm_x : '0;
      pc_d        = pc_i;
      wd_d        = inst_i[11:7];
      wreg_d      = dec.wreg;
      illegal_d   = dec.illegal;
      inst_d      = inst_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (hazard && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Output pipeline register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      out_valid_q <= 1'b0;
      alusel_q    <= '0;
      alt_q       <= 1'b0;
      opr1_q      <= '0;
      opr2_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      illegal_q   <= 1'b0;
      inst_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alusel_q    <= alusel_d;
      alt_q       <= alt_d;
      opr1_q      <= opr1_d;
      opr2_q      <= opr2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      illegal_q   <= illegal_d;
      inst_q      <= inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign alusel_o    = alusel_q;
  assign alt_o       = alt_q;
  assign opr1_o      = opr1_q;
  assign opr2_o      = opr2_q;
  assign imm_o       = imm_q;
  assign pc_o        = pc_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign illegal_o   = illegal_q;
  assign inst_o      = inst_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode table, directed handshake/forwarding
// sequences, and a randomized run against a behavioural model.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  localparam int XLEN = 32, ADDR_W = 32, NUM_FWD = 3, CNT_W = 4;

  logic clk = 1'b0;
  logic rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [ADDR_W-1:0] pc_i, pc_o;
  logic [31:0] inst_i, inst_o;
  logic [4:0] reg1_addr_o, reg2_addr_o, alusel_o, wd_o;
  logic [XLEN-1:0] reg1_data_i, reg2_data_i, opr1_o, opr2_o, imm_o;
  logic alt_o, wreg_o, illegal_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [NUM_FWD-1:0] f_we, f_pend;
  logic [4:0] f_wd [NUM_FWD];
  logic [XLEN-1:0] f_data [NUM_FWD];
  logic [5*NUM_FWD-1:0] fwd_wd_bus;
  logic [XLEN*NUM_FWD-1:0] fwd_data_bus;

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_pack
    assign fwd_wd_bus[5*g +: 5]         = f_wd[g];
    assign fwd_data_bus[XLEN*g +: XLEN] = f_data[g];
  end

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_we_i(f_we), .fwd_wd_i(fwd_wd_bus),
    .fwd_data_i(fwd_data_bus), .fwd_pending_i(f_pend), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .alusel_o(alusel_o), .alt_o(alt_o), .opr1_o(opr1_o),
    .opr2_o(opr2_o), .imm_o(imm_o), .pc_o(pc_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .illegal_o(illegal_o), .inst_o(inst_o), .stall_cnt_o(stall_cnt_o)
  );

  int n_checks = 0, n_pass = 0;

  typedef struct {
    logic [4:0] alusel; logic alt; logic [31:0] opr1, opr2, imm, pc;
    logic [4:0] wd; logic wreg, ill;
  } out_t;
  typedef struct { logic [31:0] inst; out_t e; } vec_t;
  typedef struct { logic [4:0] alusel; logic alt, r1, r2, wreg, ill; logic [31:0] imm; } rdec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".valid"},  64'(out_valid_o), 64'(1));
    check({tag, ".alusel"}, 64'(alusel_o),    64'(e.alusel));
    check({tag, ".alt"},    64'(alt_o),       64'(e.alt));
    check({tag, ".opr1"},   64'(opr1_o),      64'(e.opr1));
    check({tag, ".opr2"},   64'(opr2_o),      64'(e.opr2));
    check({tag, ".imm"},    64'(imm_o),       64'(e.imm));
    check({tag, ".pc"},     64'(pc_o),        64'(e.pc));
    check({tag, ".wd"},     64'(wd_o),        64'(e.wd));
    check({tag, ".wreg"},   64'(wreg_o),      64'(e.wreg));
    check({tag, ".illegal"},64'(illegal_o),   64'(e.ill));
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] wd,
                         input logic [31:0] data, input logic pend);
    f_we[k] = we; f_wd[k] = wd; f_data[k] = data; f_pend[k] = pend;
  endtask

  task automatic clear_fwd();
    for (int k = 0; k < NUM_FWD; k++) set_fwd(k, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Reference decode straight from the instruction-format rules
  function automatic rdec_t ref_decode(input logic [31:0] i);
    rdec_t d; int f3, ii, is_, ib, ij;
    f3  = int'(i[14:12]);
    ii  = int'($signed(i[31:20]));
    is_ = int'($signed({i[31:25], i[11:7]}));
    ib  = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    ij  = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    d = '{default: 0};
    case (i[6:0])
      7'h37: begin d.alusel = SEL_LUI;   d.wreg = 1; d.imm = i & 32'hFFFFF000; end
      7'h17: begin d.alusel = SEL_AUIPC; d.wreg = 1; d.imm = i & 32'hFFFFF000; end
      7'h6F: begin d.alusel = SEL_JAL;   d.wreg = 1; d.imm = ij; end
      7'h67: begin d.alusel = SEL_JALR;  d.wreg = 1; d.r1 = 1; d.imm = ii; end
      7'h63: begin d.alusel = 5'(16 + f3); d.r1 = 1; d.r2 = 1; d.imm = ib; end
      7'h03: begin d.alusel = 5'(24 + f3); d.r1 = 1; d.wreg = 1; d.imm = ii; end
      7'h23: begin
        if (f3 > 2) d.ill = 1;
        else begin
          d.alusel = (f3 == 0) ? SEL_SB : (f3 == 1) ? SEL_SH : SEL_SW;
          d.r1 = 1; d.r2 = 1; d.imm = is_;
        end
      end
      7'h13: begin
        d.alusel = 5'(f3); d.r1 = 1; d.wreg = 1; d.imm = ii;
        d.alt = (f3 == 1 || f3 == 5) ? i[30] : 1'b0;
      end
      7'h33: begin d.alusel = 5'(f3); d.r1 = 1; d.r2 = 1; d.wreg = 1; d.alt = i[30]; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  // Oldest source first so that a younger match overwrites an older one
  task automatic resolve(input logic [4:0] a, input logic [31:0] rf,
                         output logic [31:0] v, output logic h);
    v = rf; h = 1'b0;
    if (a == 5'd0) begin v = 32'd0; return; end
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (f_we[k] && f_wd[k] == a) begin v = f_data[k]; h = f_pend[k]; end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] i;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F, 7'h0B};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 10)];
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vt [9];
  out_t e;

  initial begin
    vt[0] = '{32'h00500093, '{5'd0,     1'b0, 32'd0,   32'd5,     32'd0, 0, 5'd1,  1'b1, 1'b0}};
    vt[1] = '{32'h402081B3, '{5'd0,     1'b1, 32'd100, 32'd30,    32'd0, 0, 5'd3,  1'b1, 1'b0}};
    vt[2] = '{32'h40335293, '{5'd5,     1'b1, 32'd100, 32'h403,   32'd0, 0, 5'd5,  1'b1, 1'b0}};
    vt[3] = '{32'hFE20AE23, '{SEL_SW,   1'b0, 32'd100, 32'd30,    32'hFFFFFFFC, 0, 5'd28, 1'b0, 1'b0}};
    vt[4] = '{32'h00208463, '{5'd16,    1'b0, 32'd100, 32'd30,    32'd8, 0, 5'd8,  1'b0, 1'b0}};
    vt[5] = '{32'h123453B7, '{SEL_LUI,  1'b0, 32'h12345000, 32'h12345000, 32'd0, 0, 5'd7, 1'b1, 1'b0}};
    vt[6] = '{32'hFFDFF0EF, '{SEL_JAL,  1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'd0, 0, 5'd1, 1'b1, 1'b0}};
    vt[7] = '{32'hFE20BE23, '{5'd0,     1'b0, 32'd0,   32'd0,     32'd0, 0, 5'd28, 1'b0, 1'b1}};
    vt[8] = '{32'h0000007F, '{5'd0,     1'b0, 32'd0,   32'd0,     32'd0, 0, 5'd0,  1'b0, 1'b1}};

    rst = 1'b1; flush_i = 0; in_valid_i = 0; out_ready_i = 1; pc_i = 0; inst_i = 0;
    reg1_data_i = 0; reg2_data_i = 0; clear_fwd();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(out_valid_o), 64'(0));
    check("rst.wreg",  64'(wreg_o),      64'(0));
    check("rst.stall", 64'(stall_cnt_o), 64'(0));
    check("rst.opr1",  64'(opr1_o),      64'(0));
    check("rst.pc",    64'(pc_o),        64'(0));
    rst = 1'b0;

    // Decode table, no forwarding, EX always ready
    reg1_data_i = 32'd100; reg2_data_i = 32'd30;
    for (int i = 0; i < 9; i++) begin
      inst_i = vt[i].inst; pc_i = 32'h1000 + 32'(4 * i); in_valid_i = 1;
      #1;
      check($sformatf("tab%0d.ready", i), 64'(in_ready_o), 64'(1));
      check($sformatf("tab%0d.rs1", i),   64'(reg1_addr_o), 64'(vt[i].inst[19:15]));
      @(posedge clk); #1;
      e = vt[i].e; e.pc = pc_i;
      check_out($sformatf("tab%0d", i), e);
    end

    // Forwarding priority: youngest source wins, rs2 from regfile
    inst_i = 32'h002081B3; reg1_data_i = 32'd55; reg2_data_i = 32'd4; pc_i = 32'h2000;
    set_fwd(0, 1, 5'd1, 32'd7, 0); set_fwd(2, 1, 5'd1, 32'd9, 0);
    #1; check("fwd.ready", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;
    check("fwd.opr1", 64'(opr1_o), 64'(7));
    check("fwd.opr2", 64'(opr2_o), 64'(4));

    // Youngest source pending for two cycles blocks even with an older ready match
    set_fwd(0, 1, 5'd1, 32'd7, 1);
    for (int c = 0; c < 2; c++) begin
      #1; check($sformatf("pend%0d.ready", c), 64'(in_ready_o), 64'(0));
      @(posedge clk); #1;
    end
    check("pend.stall", 64'(stall_cnt_o), 64'(2));
    check("pend.valid", 64'(out_valid_o), 64'(0));
    f_pend[0] = 0;
    #1; check("pend.release", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;
    check("pend.outv", 64'(out_valid_o), 64'(1));
    check("pend.opr1", 64'(opr1_o), 64'(7));

    // Backpressure holding a SUB
    clear_fwd(); reg1_data_i = 32'd100; reg2_data_i = 32'd30;
    inst_i = 32'h402081B3; pc_i = 32'h3000;
    @(posedge clk); #1;
    out_ready_i = 0; inst_i = 32'h00500093; pc_i = 32'h3004;
    for (int c = 0; c < 2; c++) begin
      #1; check($sformatf("bp%0d.ready", c), 64'(in_ready_o), 64'(0));
      @(posedge clk); #1;
      check($sformatf("bp%0d.valid", c), 64'(out_valid_o), 64'(1));
      check($sformatf("bp%0d.alt", c),   64'(alt_o),  64'(1));
      check($sformatf("bp%0d.opr1", c),  64'(opr1_o), 64'(100));
      check($sformatf("bp%0d.pc", c),    64'(pc_o),   64'(32'h3000));
      check($sformatf("bp%0d.stall", c), 64'(stall_cnt_o), 64'(2));
    end
    out_ready_i = 1;
    #1; check("bp.release", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;
    check("bp.next.opr2", 64'(opr2_o), 64'(5));
    check("bp.next.alt",  64'(alt_o),  64'(0));

    // Flush beats backpressure and a hazard
    flush_i = 1; out_ready_i = 0; inst_i = 32'h402081B3; set_fwd(0, 1, 5'd1, 32'd1, 1);
    #1; check("flush.ready", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;
    check("flush.valid", 64'(out_valid_o), 64'(0));
    check("flush.wreg",  64'(wreg_o),      64'(0));
    check("flush.stall", 64'(stall_cnt_o), 64'(2));
    flush_i = 0; clear_fwd(); out_ready_i = 1;

    // Asynchronous reset in the middle of a cycle
    inst_i = 32'h123453B7; pc_i = 32'h4000;
    @(posedge clk); #1;
    check("arst.pre", 64'(out_valid_o), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid_o), 64'(0));
    check("arst.wreg",  64'(wreg_o),      64'(0));
    check("arst.opr1",  64'(opr1_o),      64'(0));
    check("arst.inst",  64'(inst_o),      64'(0));
    check("arst.alusel",64'(alusel_o),    64'(0));
    check("arst.wd",    64'(wd_o),        64'(0));
    check("arst.stall", 64'(stall_cnt_o), 64'(0));
    in_valid_i = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Counter saturation under a long hazard
    in_valid_i = 1; inst_i = 32'h402081B3; set_fwd(0, 1, 5'd1, 32'd0, 1);
    for (int c = 1; c <= (1 << CNT_W) + 3; c++) begin
      @(posedge clk); #1;
      if (c == 14) check("sat.mid", 64'(stall_cnt_o), 64'(14));
    end
    check("sat.cnt",   64'(stall_cnt_o), 64'(15));
    check("sat.ready", 64'(in_ready_o),  64'(0));
    clear_fwd(); in_valid_i = 0;

    // Randomized run against the behavioural model
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    begin
      logic m_valid, m_wreg; int m_cnt; out_t m; logic [31:0] m_inst;
      rdec_t d; logic [31:0] v1, v2; logic h1, h2, haz, exp_ready;
      m_valid = 0; m_wreg = 0; m_cnt = 0; m = '{default: 0}; m_inst = 0;
      for (int n = 0; n < 600; n++) begin
        in_valid_i  = ($urandom_range(0, 3) != 0);
        out_ready_i = ($urandom_range(0, 3) != 0);
        flush_i     = ($urandom_range(0, 15) == 0);
        inst_i = rand_inst(); pc_i = $urandom;
        reg1_data_i = $urandom; reg2_data_i = $urandom;
        for (int k = 0; k < NUM_FWD; k++)
          set_fwd(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 4) == 0));
        d = ref_decode(inst_i);
        resolve(inst_i[19:15], reg1_data_i, v1, h1);
        resolve(inst_i[24:20], reg2_data_i, v2, h2);
        haz = in_valid_i && ((d.r1 && h1) || (d.r2 && h2));
        exp_ready = flush_i || (!haz && (!m_valid || out_ready_i));
        #1; check("rnd.ready", 64'(in_ready_o), 64'(exp_ready));
        @(posedge clk);
        if (haz && !flush_i && m_cnt < 15) m_cnt++;
        if (flush_i) begin
          m_valid = 0; m_wreg = 0;
        end else if (in_valid_i && exp_ready) begin
          m_valid = 1; m_wreg = d.wreg; m_inst = inst_i;
          m.alusel = d.alusel; m.alt = d.alt; m.wreg = d.wreg; m.ill = d.ill;
          m.opr1 = d.r1 ? v1 : d.imm; m.opr2 = d.r2 ? v2 : d.imm;
          m.imm = (d.r1 && d.r2) ? d.imm : 32'd0; m.pc = pc_i; m.wd = inst_i[11:7];
        end else if (out_ready_i) begin
          m_valid = 0;
        end
        #1;
        check("rnd.valid", 64'(out_valid_o), 64'(m_valid));
        check("rnd.wreg",  64'(wreg_o),      64'(m_wreg));
        check("rnd.stall", 64'(stall_cnt_o), 64'(m_cnt));
        if (m_valid) begin
          check_out("rnd", m);
          check("rnd.inst", 64'(inst_o), 64'(m_inst));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered successor to the combinational decode stage. Decodes one RV32I instruction per cycle and resolves rs1/rs2 through a parametrised array of forwarding sources. Data that is not ready yet (load results) is handled by a per-source pending flag. Presents the result in a pipeline register with valid/ready handshake; sits between the IF/ID register and EX. Adds SUB/SRA (funct7[5]) decode, illegal-instruction flagging, branch flush and a saturating hazard-stall counter.

Parameters:
XLEN, 32, register/data width
ADDR_W, 32, instruction address width
NUM_FWD, 3, number of forwarding sources; index 0 = youngest stage (highest priority)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush_i  in  1  branch interception; kills the stage
in_valid_i  in  1  IF/ID holds an instruction
in_ready_o  out  1  stage accepts the instruction this cycle
pc_i  in  ADDR_W  instruction PC
inst_i  in  32  instruction word
reg1_addr_o  out  5  rs1 = inst_i[19:15], combinational
reg2_addr_o  out  5  rs2 = inst_i[24:20], combinational
reg1_data_i  in  XLEN  regfile rs1 data
reg2_data_i  in  XLEN  regfile rs2 data
fwd_we_i  in  NUM_FWD  source k writes a register
fwd_wd_i  in  5*NUM_FWD  destination of source k, slice [5k+4:5k]
fwd_data_i  in  XLEN*NUM_FWD  result of source k
fwd_pending_i  in  NUM_FWD  source k result not yet available
out_valid_o  out  1  output register holds a decoded instruction
out_ready_i  in  1  EX accepts
alusel_o  out  5  operation select (package encoding)
alt_o  out  1  funct7[5] for OP, and for OP-IMM shifts (SUB/SRA/SRAI)
opr1_o  out  XLEN  rs1 value if read, else imm
opr2_o  out  XLEN  rs2 value if read, else imm
imm_o  out  XLEN  imm when both rs1 and rs2 are read (branch/store), else 0
pc_o  out  ADDR_W  PC of the decoded instruction
wd_o  out  5  rd
wreg_o  out  1  writes rd
illegal_o  out  1  unrecognised opcode or funct3
inst_o  out  32  raw instruction, debug
stall_cnt_o  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Reset (async): out_valid_o, wreg_o, illegal_o, alusel_o, alt_o, wd_o, stall_cnt_o are 0; opr1/2, imm, pc, inst registers are 0.
- Latency: 1 cycle. Operands are sampled in the accept cycle and registered.
- Immediates (sign-extended):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Read flags:
  - rs1: OP-IMM, OP, JALR, BRANCH, LOAD, STORE
  - rs2: OP, BRANCH, STORE
- Write flag (wreg): LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- alusel:
  - OP/OP-IMM: {2'b00, funct3}
  - BRANCH: {2'b10, funct3}
  - LOAD: {2'b11, funct3}
  - STORE: SEL_SB/SH/SW
  - LUI/AUIPC/JAL/JALR: package constants
- Illegal instructions (unknown opcode, or STORE funct3 > 2): decoded as NOP (wreg=0, alusel=0) with illegal_o=1. They still flow through the stage.
- Operand resolution, per source operand that is read:
  - Address 0 → value 0, never a hazard.
  - Otherwise take the lowest k with fwd_we_i[k] and fwd_wd_i[k] equal to the address.
    - If fwd_pending_i[k] → hazard.
    - Else → fwd_data_i[k].
  - No match → regfile data.
  - Older matching sources never override younger ones, even if the younger one is pending.
- hazard = hazard_rs1 | hazard_rs2, valid only when in_valid_i.
- in_ready_o = flush_i | (!hazard & (!out_valid_o | out_ready_i)).
- Capture when in_valid_i & in_ready_o & !flush_i: out_valid_o ← 1.
- Otherwise, if out_ready_i: out_valid_o ← 0. Data registers hold while out_valid_o & !out_ready_i.
- Flush has priority over everything:
  - Next cycle out_valid_o = 0 and wreg_o = 0.
  - The incoming instruction is consumed and discarded (in_ready_o = 1).
- Stall counter: +1 each cycle with in_valid_i & hazard & !flush_i. Saturates at all-ones; never wraps.
- Backpressure without hazard: in_ready_o = 0 and the counter does not increment.

Decomposition:
- Shared package (defines): opcode constants; SEL_* alusel encodings (SEL_LUI, SEL_AUIPC, SEL_JAL, SEL_JALR, SEL_SB, SEL_SH, SEL_SW); RstEnable/WriteEnable.
- Sub-module id_fwd_mux (instantiated twice):
  - Inputs: address, read flag, regfile data, forwarding arrays.
  - Outputs: value and hazard.
  - Priority loop over NUM_FWD.

Test Plan:
- ADDI x1,x0,5 (0x00500093) with no forwarding, out_ready=1 → next cycle out_valid=1, opr1=0, opr2=5, wd=1, wreg=1, alusel=0.
- ADD x3,x1,x2 with fwd0 {we=1, wd=1, data=7, pending=0}, fwd2 {we=1, wd=1, data=9}, regfile x2=4 → opr1=7, opr2=4.
- Same ADD with fwd0 pending=1 for x1 for 2 cycles → in_ready=0 for 2 cycles, stall_cnt=2, then accepted with the forwarded data.
- out_ready=0 holding a SUB (alt=1), next instruction valid → output stable and in_ready=0, stall_cnt unchanged.
- flush_i while out_valid=1 and in_valid=1 → next cycle out_valid=0, input consumed; async rst mid-stream clears all outputs immediately.
- SW with funct3=3'b011 → illegal_o=1, wreg=0, alusel=0; hold a hazard for 2^CNT_W+3 cycles with CNT_W=4 → stall_cnt saturates at 15.
